// File: rtl/sdram_byte_port_if.sv
// -----------------------------------------------------------------------------
// sdram_byte_port_if
//   Groups the byte-wide CPU-side signals and the SDRAM controller-side
//   signals of one sdram_byte_port instance.
//
//   CPU side   : cpu_req, cpu_we, cpu_a, cpu_d, flush   (to the port)
//                cpu_q, cpu_done, busy                  (from the port)
//   SDRAM side : sdram_req, sdram_we, sdram_a,
//                sdram_ds, sdram_d                      (from the port)
//                sdram_ack, sdram_q                     (to the port)
//
//   The slave modport is the port's own view.
//   The master modport is the view of the surroundings: the CPU plus the
//   controller port.
// -----------------------------------------------------------------------------
interface sdram_byte_port_if #(
   parameter int ADDR_W = 24
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_a;
   logic [7:0]        cpu_d;
   logic [7:0]        cpu_q;
   logic              cpu_done;
   logic              busy;
   logic              flush;
   logic              sdram_req;
   logic              sdram_ack;
   logic              sdram_we;
   logic [ADDR_W-2:0] sdram_a;
   logic [1:0]        sdram_ds;
   logic [15:0]       sdram_d;
   logic [15:0]       sdram_q;

   modport master (
      output cpu_req, cpu_we, cpu_a, cpu_d, flush,
      input  cpu_q, cpu_done, busy,
      input  sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d,
      output sdram_ack, sdram_q
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_a, cpu_d, flush,
      output cpu_q, cpu_done, busy,
      output sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d,
      input  sdram_ack, sdram_q
   );
endinterface

// File: rtl/sdram_byte_port.sv
// -----------------------------------------------------------------------------
// sdram_byte_port
//   Byte-wide front end for one port of the dual-port SDRAM controller.
//
//   - Converts single-cycle byte requests into the controller's toggle
//     req/ack handshake, using 16-bit words and byte strobes.
//   - Keeps a one-word read cache, so repeated byte reads of the same word
//     finish in one cycle with no SDRAM access.
//
//   Ports:
//     clk    : system clock, shared with the SDRAM controller.
//     init_n : asynchronous, active-low reset.
//     bus    : sdram_byte_port_if.slave, carrying the CPU-side and
//              controller-side signals.
//
//   Parameter:
//     ADDR_W : byte address width.
//              The SDRAM word address is cpu_a[ADDR_W-1:1].
// -----------------------------------------------------------------------------
module sdram_byte_port #(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              init_n,
   sdram_byte_port_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   state_t            state_reg;
   logic              we_reg;           // latched direction of the request in flight
   logic              a0_reg;           // latched byte select of the request in flight
   logic              sdram_req_reg;
   logic              sdram_we_reg;
   logic [ADDR_W-2:0] sdram_a_reg;      // also serves as the latched word address
   logic [1:0]        sdram_ds_reg;
   logic [15:0]       sdram_d_reg;      // holds the latched write byte in both lanes
   logic [7:0]        cpu_q_reg;
   logic              cpu_done_reg;
   logic              busy_reg;
   logic [15:0]       cache_data_reg;
   logic [ADDR_W-2:0] cache_tag_reg;
   logic              cache_valid_reg;

   logic              read_hit;
   logic              ack_equal;

   // A flush raised in the same cycle as a request turns it into a miss.
   assign read_hit  = !bus.cpu_we && cache_valid_reg && !bus.flush &&
                      (cache_tag_reg == bus.cpu_a[ADDR_W-1:1]);

   // Equal req/ack parity means the controller has finished the transaction.
   assign ack_equal = (bus.sdram_ack == sdram_req_reg);

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_reg       <= ST_IDLE;
         we_reg          <= 1'b0;
         a0_reg          <= 1'b0;
         sdram_req_reg   <= 1'b0;
         sdram_we_reg    <= 1'b0;
         sdram_a_reg     <= '0;
         sdram_ds_reg    <= 2'b00;
         sdram_d_reg     <= 16'h0000;
         cpu_q_reg       <= 8'h00;
         cpu_done_reg    <= 1'b0;
         busy_reg        <= 1'b0;
         cache_data_reg  <= 16'h0000;
         cache_tag_reg   <= '0;
         cache_valid_reg <= 1'b0;
      end else begin
         cpu_done_reg <= 1'b0;

         // Flush invalidates the cache in every state.
         // A read refill completing on this same edge overrides it below.
         if (bus.flush) begin
            cache_valid_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (bus.cpu_req) begin
                  busy_reg <= 1'b1;
                  we_reg   <= bus.cpu_we;
                  a0_reg   <= bus.cpu_a[0];
                  if (read_hit) begin
                     state_reg <= ST_HIT;
                  end else begin
                     sdram_a_reg   <= bus.cpu_a[ADDR_W-1:1];
                     sdram_ds_reg  <= bus.cpu_a[0] ? 2'b10 : 2'b01;
                     sdram_d_reg   <= {bus.cpu_d, bus.cpu_d};
                     sdram_we_reg  <= bus.cpu_we;
                     sdram_req_reg <= ~sdram_req_reg;
                     state_reg     <= ST_WAIT;
                  end
               end
            end

            ST_HIT: begin
               cpu_q_reg    <= a0_reg ? cache_data_reg[15:8] : cache_data_reg[7:0];
               cpu_done_reg <= 1'b1;
               busy_reg     <= 1'b0;
               state_reg    <= ST_IDLE;
            end

            ST_WAIT: begin
               // The sdram_* outputs are left untouched here.
               // They stay stable until the controller acknowledges.
               if (ack_equal) begin
                  if (!we_reg) begin
                     cpu_q_reg       <= a0_reg ? bus.sdram_q[15:8] : bus.sdram_q[7:0];
                     cache_data_reg  <= bus.sdram_q;
                     cache_tag_reg   <= sdram_a_reg;
                     cache_valid_reg <= 1'b1;
                  end else if (cache_valid_reg && (cache_tag_reg == sdram_a_reg)) begin
                     // Write-through: keep the cached word coherent with SDRAM.
                     // Writes never allocate a new line.
                     if (a0_reg) begin
                        cache_data_reg[15:8] <= sdram_d_reg[15:8];
                     end else begin
                        cache_data_reg[7:0]  <= sdram_d_reg[7:0];
                     end
                  end
                  cpu_done_reg <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sdram_req = sdram_req_reg;
   assign bus.sdram_we  = sdram_we_reg;
   assign bus.sdram_a   = sdram_a_reg;
   assign bus.sdram_ds  = sdram_ds_reg;
   assign bus.sdram_d   = sdram_d_reg;
   assign bus.cpu_q     = cpu_q_reg;
   assign bus.cpu_done  = cpu_done_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_sdram_byte_port.sv
// -----------------------------------------------------------------------------
// tb_sdram_byte_port
//   Self-checking bench for sdram_byte_port.
//
//   - The bench models the SDRAM controller port with a small word memory
//     and a random acknowledge latency.
//   - Expected behaviour comes from a byte-level memory image plus a
//     one-word cache model (valid bit and tag).
// -----------------------------------------------------------------------------
module tb_sdram_byte_port;
   localparam int AW = 24;

   logic clk;
   logic init_n;

   sdram_byte_port_if #(.ADDR_W(AW)) bus ();

   sdram_byte_port #(.ADDR_W(AW)) dut (
      .clk    (clk),
      .init_n (init_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Controller-port model.
   logic [15:0] sdram_mem [0:63];
   int resp_wait  = -1;
   int resp_fixed = -1;   // >=0 forces a fixed acknowledge latency

   always @(negedge clk) begin
      if (!init_n) begin
         bus.sdram_ack = 1'b0;
         resp_wait     = -1;
      end else if (bus.sdram_req != bus.sdram_ack) begin
         if (resp_wait < 0) begin
            resp_wait = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 3));
         end
         if (resp_wait == 0) begin
            if (bus.sdram_we) begin
               if (bus.sdram_ds[1]) sdram_mem[bus.sdram_a[5:0]][15:8] = bus.sdram_d[15:8];
               if (bus.sdram_ds[0]) sdram_mem[bus.sdram_a[5:0]][7:0]  = bus.sdram_d[7:0];
            end
            bus.sdram_q   = sdram_mem[bus.sdram_a[5:0]];
            bus.sdram_ack = bus.sdram_req;
            resp_wait     = -1;
         end else begin
            resp_wait--;
         end
      end
   end

   // Monitors: counts of req toggles and of cycles with cpu_done high.
   int tog_cnt  = 0;
   int done_cnt = 0;
   always @(bus.sdram_req) tog_cnt++;
   always @(negedge clk) if (bus.cpu_done === 1'b1) done_cnt++;

   // Reference model: byte image of memory plus cache valid/tag.
   logic [7:0] ref_mem [0:127];
   bit         ref_valid;
   int         ref_tag;

   task automatic model_op(input bit we, input int a, input logic [7:0] d, input bit fl,
                           output bit hit, output logic [7:0] q);
      hit = !we && ref_valid && (ref_tag == a / 2) && !fl;
      if (we) ref_mem[a] = d;
      q = ref_mem[a];
      if (!we) begin
         ref_valid = 1'b1;
         ref_tag   = a / 2;
      end else if (fl) begin
         ref_valid = 1'b0;
      end
   endtask

   // Issues one request and reports what was observed.
   // Called at a negedge; returns one negedge after cpu_done was seen.
   task automatic do_op(input bit we, input int a, input logic [7:0] d, input bit fl,
                        output bit got_done, output int cyc, output int tog,
                        output logic [7:0] q, output logic [AW-2:0] sa,
                        output logic [1:0] ds, output logic [15:0] sd, output logic swe,
                        output bit stable, output logic busy_done, output logic done_after);
      int t0;
      int guard;
      guard = 0;
      while (bus.busy === 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      t0 = tog_cnt;
      bus.cpu_req = 1'b1;
      bus.cpu_we  = we;
      bus.cpu_a   = AW'(a);
      bus.cpu_d   = d;
      bus.flush   = fl;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.flush   = 1'b0;
      sa  = bus.sdram_a;
      ds  = bus.sdram_ds;
      sd  = bus.sdram_d;
      swe = bus.sdram_we;
      stable = 1'b1;
      cyc    = 1;
      while (bus.cpu_done !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.sdram_a !== sa || bus.sdram_ds !== ds || bus.sdram_d !== sd || bus.sdram_we !== swe)
            stable = 1'b0;
      end
      got_done  = (bus.cpu_done === 1'b1);
      q         = bus.cpu_q;
      busy_done = bus.busy;
      tog       = tog_cnt - t0;
      @(negedge clk);
      done_after = bus.cpu_done;
      $display("op we=%0b a=0x%06h d=0x%02h flush=%0b -> q=0x%02h cycles=%0d toggles=%0d",
               we, a, d, fl, q, cyc, tog);
   endtask

   // Shared observation variables (only one test runs at a time).
   bit          o_done, o_stable, e_hit;
   int          o_cyc, o_tog;
   logic [7:0]  o_q, e_q;
   logic [AW-2:0] o_sa;
   logic [1:0]  o_ds;
   logic [15:0] o_sd;
   logic        o_swe, o_busy, o_after;

   task automatic test_reset();
      init_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 init_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.sdram_req !== 1'b0) begin n_errors++; $display("FAIL reset_sdram_req got=%b exp=0", bus.sdram_req); end
      n_checks++; if (bus.sdram_we !== 1'b0) begin n_errors++; $display("FAIL reset_sdram_we got=%b exp=0", bus.sdram_we); end
      n_checks++; if (bus.sdram_a !== '0) begin n_errors++; $display("FAIL reset_sdram_a got=%h exp=0", bus.sdram_a); end
      n_checks++; if (bus.sdram_ds !== 2'b00) begin n_errors++; $display("FAIL reset_sdram_ds got=%b exp=00", bus.sdram_ds); end
      n_checks++; if (bus.sdram_d !== 16'h0) begin n_errors++; $display("FAIL reset_sdram_d got=%h exp=0", bus.sdram_d); end
      n_checks++; if (bus.cpu_q !== 8'h0) begin n_errors++; $display("FAIL reset_cpu_q got=%h exp=0", bus.cpu_q); end
      n_checks++; if (bus.cpu_done !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_done_busy got=%b%b exp=00", bus.cpu_done, bus.busy); end
      ref_valid = 1'b0;
   endtask

   task automatic test_read_miss();
      model_op(1'b0, 4, 8'h00, 1'b0, e_hit, e_q);
      do_op(1'b0, 4, 8'h00, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (!o_done) begin n_errors++; $display("FAIL miss_done got=timeout exp=cpu_done"); end
      n_checks++; if (o_tog != 1) begin n_errors++; $display("FAIL miss_toggles got=%0d exp=1", o_tog); end
      n_checks++; if (o_sa !== 23'h000002) begin n_errors++; $display("FAIL miss_sdram_a got=%h exp=000002", o_sa); end
      n_checks++; if (o_ds !== 2'b01) begin n_errors++; $display("FAIL miss_sdram_ds got=%b exp=01", o_ds); end
      n_checks++; if (o_q !== 8'h34) begin n_errors++; $display("FAIL miss_cpu_q got=%h exp=34", o_q); end
      n_checks++; if (o_busy !== 1'b0 || o_after !== 1'b0) begin n_errors++; $display("FAIL miss_pulse busy=%b done_next=%b exp=0 0", o_busy, o_after); end
   endtask

   task automatic test_read_hit();
      model_op(1'b0, 5, 8'h00, 1'b0, e_hit, e_q);
      do_op(1'b0, 5, 8'h00, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (o_tog != 0) begin n_errors++; $display("FAIL hit_toggles got=%0d exp=0", o_tog); end
      n_checks++; if (o_cyc != 2) begin n_errors++; $display("FAIL hit_latency got=%0d exp=2", o_cyc); end
      n_checks++; if (o_q !== 8'h12) begin n_errors++; $display("FAIL hit_cpu_q got=%h exp=12", o_q); end
   endtask

   task automatic test_write_through();
      model_op(1'b1, 5, 8'hAB, 1'b0, e_hit, e_q);
      do_op(1'b1, 5, 8'hAB, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (o_tog != 1) begin n_errors++; $display("FAIL wr_toggles got=%0d exp=1", o_tog); end
      n_checks++; if (o_ds !== 2'b10 || o_sd !== 16'hABAB || o_swe !== 1'b1) begin n_errors++; $display("FAIL wr_bus got=ds %b d %h we %b exp=ds 10 d abab we 1", o_ds, o_sd, o_swe); end
      n_checks++; if (sdram_mem[2] !== 16'hAB34) begin n_errors++; $display("FAIL wr_memory got=%h exp=ab34", sdram_mem[2]); end
      model_op(1'b0, 5, 8'h00, 1'b0, e_hit, e_q);
      do_op(1'b0, 5, 8'h00, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (o_tog != 0 || o_cyc != 2) begin n_errors++; $display("FAIL wr_then_hit got=toggles %0d cycles %0d exp=0 2", o_tog, o_cyc); end
      n_checks++; if (o_q !== 8'hAB) begin n_errors++; $display("FAIL wr_then_hit_q got=%h exp=ab", o_q); end
   endtask

   task automatic test_flush();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      ref_valid = 1'b0;
      model_op(1'b0, 4, 8'h00, 1'b0, e_hit, e_q);
      do_op(1'b0, 4, 8'h00, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (o_tog != 1) begin n_errors++; $display("FAIL flush_miss_toggles got=%0d exp=1", o_tog); end
      n_checks++; if (o_q !== e_q) begin n_errors++; $display("FAIL flush_miss_q got=%h exp=%h", o_q, e_q); end
   endtask

   task automatic test_busy_ignore();
      int t0, d0, guard;
      logic [AW-2:0] sa0;
      bit moved;
      resp_fixed = 8;
      model_op(1'b0, 16, 8'h00, 1'b0, e_hit, e_q);
      t0 = tog_cnt;
      d0 = done_cnt;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = AW'(16);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      sa0   = bus.sdram_a;
      moved = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = AW'($urandom_range(32, 63)); bus.cpu_d = 8'($urandom);
         @(negedge clk);
         bus.cpu_req = 1'b0;
         if (bus.sdram_a !== sa0) moved = 1'b1;
         @(negedge clk);
      end
      guard = 0;
      while (bus.cpu_done !== 1'b1 && guard < 40) begin
         if (bus.sdram_a !== sa0) moved = 1'b1;
         @(negedge clk);
         guard++;
      end
      o_q = bus.cpu_q;
      repeat (4) @(negedge clk);
      $display("op busy-ignore a=0x000010 -> q=0x%02h toggles=%0d dones=%0d", o_q, tog_cnt - t0, done_cnt - d0);
      n_checks++; if (tog_cnt - t0 != 1) begin n_errors++; $display("FAIL busy_toggles got=%0d exp=1", tog_cnt - t0); end
      n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL busy_dones got=%0d exp=1", done_cnt - d0); end
      n_checks++; if (moved || sa0 !== 23'h000008) begin n_errors++; $display("FAIL busy_sdram_a got=%h moved=%0b exp=000008 0", sa0, moved); end
      n_checks++; if (o_q !== e_q) begin n_errors++; $display("FAIL busy_q got=%h exp=%h", o_q, e_q); end
      resp_fixed = -1;
   endtask

   task automatic test_reset_mid_wait();
      resp_fixed = 6;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = AW'(32);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1 || bus.sdram_req === bus.sdram_ack) begin n_errors++; $display("FAIL rst_pre_wait got=busy %b req %b ack %b exp=busy 1 req!=ack", bus.busy, bus.sdram_req, bus.sdram_ack); end
      #2 init_n = 1'b0;
      #1;
      n_checks++; if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_async got=req %b busy %b exp=0 0", bus.sdram_req, bus.busy); end
      @(negedge clk);
      #2 init_n = 1'b1;
      ref_valid  = 1'b0;
      resp_fixed = -1;
      @(negedge clk);
      // Word 8 was cached before the reset, so it must now miss.
      model_op(1'b0, 17, 8'h00, 1'b0, e_hit, e_q);
      do_op(1'b0, 17, 8'h00, 1'b0, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
      n_checks++; if (o_tog != 1) begin n_errors++; $display("FAIL rst_then_miss got=%0d exp=1", o_tog); end
      n_checks++; if (o_q !== e_q) begin n_errors++; $display("FAIL rst_then_q got=%h exp=%h", o_q, e_q); end
   endtask

   task automatic test_random();
      bit we, fl;
      int a;
      logic [7:0] d;
      for (int n = 0; n < 40; n++) begin
         we = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 7) == 0);
         a  = int'($urandom_range(0, 15));
         d  = 8'($urandom);
         model_op(we, a, d, fl, e_hit, e_q);
         do_op(we, a, d, fl, o_done, o_cyc, o_tog, o_q, o_sa, o_ds, o_sd, o_swe, o_stable, o_busy, o_after);
         n_checks++; if (!o_done) begin n_errors++; $display("FAIL rnd_done n=%0d got=timeout exp=cpu_done", n); end
         if (e_hit) begin
            n_checks++; if (o_tog != 0 || o_cyc != 2) begin n_errors++; $display("FAIL rnd_hit n=%0d got=toggles %0d cycles %0d exp=0 2", n, o_tog, o_cyc); end
         end else begin
            n_checks++; if (o_tog != 1) begin n_errors++; $display("FAIL rnd_miss n=%0d got=toggles %0d exp=1", n, o_tog); end
            n_checks++; if (o_sa !== 23'(a / 2) || o_ds !== (a[0] ? 2'b10 : 2'b01) || o_swe !== we) begin n_errors++; $display("FAIL rnd_bus n=%0d got=a %h ds %b we %b exp=a %h a0 %0d we %b", n, o_sa, o_ds, o_swe, a / 2, a % 2, we); end
            n_checks++; if (!o_stable) begin n_errors++; $display("FAIL rnd_stable n=%0d got=changed exp=stable", n); end
            if (we) begin
               n_checks++; if (o_sd !== {d, d}) begin n_errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o_sd, {d, d}); end
            end
         end
         if (!we) begin
            n_checks++; if (o_q !== e_q) begin n_errors++; $display("FAIL rnd_q n=%0d a=%0d got=%h exp=%h", n, a, o_q, e_q); end
         end
         n_checks++; if (o_after !== 1'b0) begin n_errors++; $display("FAIL rnd_pulse n=%0d got=%b exp=0", n, o_after); end
      end
   endtask

   initial begin
      init_n        = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_a     = '0;
      bus.cpu_d     = 8'h00;
      bus.flush     = 1'b0;
      bus.sdram_ack = 1'b0;
      bus.sdram_q   = 16'h0000;
      for (int i = 0; i < 64; i++) sdram_mem[i] = 16'($urandom);
      sdram_mem[2] = 16'h1234;
      for (int i = 0; i < 64; i++) begin
         ref_mem[2*i]   = sdram_mem[i][7:0];
         ref_mem[2*i+1] = sdram_mem[i][15:8];
      end
      ref_valid = 1'b0;
      ref_tag   = 0;

      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_through();
      test_flush();
      test_busy_ignore();
      test_reset_mid_wait();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sdram_byte_port.md
# sdram_byte_port

Byte-wide front end for one port of the dual-port SDRAM controller, placed directly upstream of it. It turns single-cycle byte read/write requests from the CPU side into the controller's toggle request/acknowledge protocol with 16-bit words and byte strobes. It keeps a one-word read cache so repeated byte reads of the same word complete without an SDRAM cycle.

## Interface
Parameters:
- ADDR_W, 24, byte address width; the SDRAM word address is cpu_a[ADDR_W-1:1].

Ports:
- clk  in  1  system clock; the same clock as the SDRAM controller.
- init_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  one-cycle request strobe; sampled only while busy=0.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_a  in  ADDR_W  byte address; bit 0 selects the byte (0 = low byte [7:0], 1 = high byte [15:8]).
- cpu_d  in  8  write data.
- cpu_q  out  8  read data; held until the next read completes.
- cpu_done  out  1  one-cycle pulse when a read or write completes.
- busy  out  1  high from the accepted request until cpu_done, inclusive of the request cycle's next edge.
- flush  in  1  invalidates the read cache; a flush in the same cycle as a hit makes that request a miss.
- sdram_req  out  1  toggle request to the controller port.
- sdram_ack  in  1  toggle acknowledge from the controller port.
- sdram_we  out  1  write enable.
- sdram_a  out  ADDR_W-1  word address [ADDR_W-1:1].
- sdram_ds  out  2  byte strobes {high, low}.
- sdram_d  out  16  write data.
- sdram_q  in  16  read data; valid in the cycle sdram_ack becomes equal to sdram_req.

## Operation
- Reset values: sdram_req=0, sdram_we=0, sdram_a=0, sdram_ds=2'b00, sdram_d=0, cpu_q=0, cpu_done=0, busy=0, cache invalid, state IDLE.
- States: IDLE, WAIT, and HIT (one cycle).
- **IDLE**, when cpu_req=1:
  - Latch cpu_we, cpu_a and cpu_d. Drive busy=1 from the next edge.
  - Read hit (cache valid, tag == cpu_a[ADDR_W-1:1], flush=0): go to HIT. The SDRAM port is untouched.
  - Miss, or any write: drive sdram_a=cpu_a[ADDR_W-1:1]. Set sdram_ds=2'b10 if cpu_a[0]=1, else 2'b01. Set sdram_d={cpu_d,cpu_d} and sdram_we=cpu_we. Toggle sdram_req. Go to WAIT.
- **HIT**: cpu_q = the selected byte of the cached word; pulse cpu_done; busy=0; back to IDLE.
- **WAIT**: on the first cycle sdram_ack==sdram_req:
  - Read: cpu_q = sdram_q[15:8] if the latched a[0]=1, else sdram_q[7:0]. Load the full sdram_q into the cache, with the tag, and mark it valid.
  - Write: if the cache is valid and the tag matches, overwrite only the written byte in the cache (write-through).
  - Pulse cpu_done, clear busy, return to IDLE.
- sdram_a, sdram_ds, sdram_d and sdram_we are held stable throughout WAIT.
- cpu_req while busy=1 is ignored, with no side effects.
- flush in any state invalidates the cache at the next edge. A read already in WAIT still refills the cache at completion, since flush precedes the fill.
- init_n asserted mid-transaction: everything returns to reset values. The controller port must be reset in the same domain, because req/ack parity restarts at 0=0.
- The cache is never filled by writes; only reads allocate.

## Timing
- Request accepted on the edge where cpu_req=1 and busy=0. The sdram_req toggle is visible after that edge.
- Hit latency: cpu_done asserted in the cycle after acceptance (1 cycle).
- Miss/write latency: cpu_done is registered in the cycle after sdram_ack equality is sampled. Total = controller latency + 1.
- The earliest next request is the cycle cpu_done is high, because busy is already 0 then.
- sdram_req toggles exactly once per SDRAM transaction. Never toggle again while sdram_req != sdram_ack.

## Test plan
- Reset, then read at 0x000004 (word 0x1234 in SDRAM):
  - Expect sdram_req 0→1, sdram_a=0x000002, sdram_ds=01.
  - After ack, cpu_q=0x34, one cpu_done pulse, busy=0.
- Read 0x000005 right after:
  - Expect no sdram_req toggle.
  - cpu_done one cycle after acceptance, cpu_q=0x12.
- Write 0xAB to 0x000005:
  - Expect sdram_ds=10, sdram_d=0xABAB, sdram_we=1, one req toggle.
  - A following read of 0x000005 hits with cpu_q=0xAB and no toggle.
- Assert flush for one cycle, then read 0x000004:
  - Expect an SDRAM transaction (miss).
- Pulse cpu_req three times while busy:
  - Expect exactly one req toggle and one cpu_done.
  - sdram_a stays unchanged throughout WAIT.
- Assert init_n=0 during WAIT:
  - Expect immediate sdram_req=0, busy=0, cache invalid.
  - The next read after release is a miss.
